lc3_sram_responder: RTL and testbench
=====================================

Name: lc3_sram_responder

Overview:
- Memory-side responder for the LC-3 datapath's SRAM interface. Samples the controller's active-low strobes (Mem_CE/OE/WE/UB/LB) plus address and write data, then serves reads and writes from an internal 16-bit word array.
- Applies configurable wait states and byte-lane masking, and reports completion on Ready.
- Sits between the CPU datapath (MAR/MDR) and on-chip storage. Replaces the external SRAM in simulation and in FPGA builds.

Parameters:
- ADDR_W, 10: word-address width; array depth is 2**ADDR_W words of 16 bits.
- READ_LAT, 1: cycles from the first sampled read strobe to read data valid; legal range 1..7.
- WRITE_LAT, 1: additional cycles WE must stay low after the first sample before the write commits; legal range 1..7.

Ports:
- Clk  in  1  clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Mem_CE  in  1  chip enable, active low.
- Mem_OE  in  1  output enable (read strobe), active low.
- Mem_WE  in  1  write enable, active low.
- Mem_UB  in  1  upper byte lane [15:8] enable, active low.
- Mem_LB  in  1  lower byte lane [7:0] enable, active low.
- ADDR  in  ADDR_W  word address; latched on access start.
- Data_from_CPU  in  16  write data; latched on access start.
- Data_to_CPU  out  16  registered read data.
- Ready  out  1  high while read data is valid or the write has committed.
- Conflict  out  1  one-cycle pulse when OE and WE are both low at access start.
- Switches  in  16  I/O read source (LC3_MMIO_EN only).
- Hex_out  out  16  I/O write register (LC3_MMIO_EN only).

Behaviour:
- Reset: state IDLE, counter 0, Data_to_CPU=0x0000, Ready=0, Conflict=0, Hex_out=0x0000. The array is not cleared. Reset mid-access aborts the access with no write.
- Access start: in IDLE, an access starts in the cycle where CE=0 and (OE=0 or WE=0); call this cycle 0.
  - ADDR, Data_from_CPU, UB and LB are latched at the end of cycle 0.
  - If WE=0 the access is a write; this takes priority over OE, and Conflict pulses in cycle 1.
- States:
  - IDLE: waiting for an access start.
  - RD_WAIT: counter runs to READ_LAT-1. At the edge ending cycle READ_LAT-1, Data_to_CPU is loaded and Ready is set; next state RD_VALID.
    - With READ_LAT=1, RD_WAIT is skipped: the load happens at the end of cycle 0 and data is valid in cycle 1.
  - RD_VALID: Data_to_CPU is held and Ready stays high while CE=0 and OE=0. If either goes high: next state IDLE, Ready=0, Data_to_CPU holds its value.
  - WR_WAIT: counter runs to WRITE_LAT. At the edge ending cycle WRITE_LAT, the enabled lanes of mem[addr] are updated and Ready is set; next state WR_DONE.
  - WR_DONE: holds Ready=1 while CE=0 and WE=0. On release: next state IDLE, Ready=0.
- Abort: CE, or the active strobe, going high before completion returns to IDLE. Ready stays 0, no array write occurs, and Data_to_CPU is unchanged.
- Back-to-back accesses: a new access requires at least one cycle with strobes released. ADDR changes during RD_VALID/WR_DONE are ignored.
- Byte lanes:
  - Write: UB=0 updates [15:8] and LB=0 updates [7:0]; a disabled lane keeps its old contents.
  - Read: a disabled lane returns 0x00. UB=LB=1 on a write commits nothing but still completes with Ready.
- Address wrap: ADDR is exactly ADDR_W bits, so there is no out-of-range case.
- Timing with READ_LAT=WRITE_LAT=1 matches the controller's 2-cycle OE and 2-cycle WE sequences: MDR captures in the second OE cycle, and the write commits in the second WE cycle.

Optional Feature:
- Macro: LC3_MMIO_EN.
- Defined: ADDR all-ones is an I/O location.
  - Reads return Switches, sampled at the load edge.
  - Writes update Hex_out using the byte-lane rules; the array is not written.
  - Latency and Ready are unchanged.
- Undefined: ADDR all-ones is ordinary memory, Switches is ignored, and Hex_out is tied to 0x0000.

Test Plan:
- Reset, then a write with ADDR=0x005, Data=0xBEEF, UB=LB=0, WE low 2 cycles -> Ready=1 in cycle 2, mem[5]=0xBEEF. Then a read with OE low 2 cycles -> Data_to_CPU=0xBEEF with Ready=1 in cycle 1.
- mem[5]=0xBEEF; write Data=0x1234 with UB=1, LB=0 -> mem[5]=0xBE34. A read with UB=0, LB=1 then returns 0xBE00.
- WE low for 1 cycle to ADDR=0x006 holding 0x0000, then released -> abort: Ready never high, mem[6] stays 0x0000, state returns to IDLE.
- OE and WE both low at start, ADDR=0x007, Data=0x00FF -> Conflict=1 for exactly cycle 1, write commits 0x00FF, Data_to_CPU unchanged.
- READ_LAT=3, read ADDR=0x005 -> Ready=0 in cycles 1-2, Ready=1 with 0xBEEF in cycle 3. Reset asserted in cycle 1 of a write -> no commit, all outputs return to reset values.
- LC3_MMIO_EN defined, ADDR=0x3FF:
  - Switches=0xA5A5, read -> Data_to_CPU=0xA5A5.
  - Write 0x0042 -> Hex_out=0x0042, mem[0x3FF] unchanged.

Source files
------------

// File: rtl/lc3_sram_responder.sv
// lc3_sram_responder: on-chip stand-in for the LC-3 external SRAM.
// Samples active-low strobes, serves reads and writes from a 16-bit word
// array with configurable wait states and byte-lane masking.
// Optional build macro: LC3_MMIO_EN maps the all-ones word address onto
// Switches (read) and Hex_out (write). Without it that address is plain
// memory and Hex_out is held at zero.
//
// Handshake: an access starts in IDLE when CE=0 and (OE=0 or WE=0).
// Ready is high only while read data is valid (RD_VALID) or the write has
// committed (WR_DONE). The controller ends an access by raising CE or the
// active strobe. Any release before completion aborts the access with no
// side effects.
module lc3_sram_responder #(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 1,   // legal range 1..7
  parameter int WRITE_LAT = 1    // legal range 1..7
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_from_CPU,
  output logic [15:0]       Data_to_CPU,
  output logic              Ready,
  output logic              Conflict,
  input  logic [15:0]       Switches,
  output logic [15:0]       Hex_out,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_VALID = 3'd2,
    WR_WAIT  = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  // Counter value in the last wait cycle of each access type.
  localparam logic [2:0] RD_LAST = 3'(READ_LAT - 1);
  localparam logic [2:0] WR_LAST = 3'(WRITE_LAT);
  localparam bit         RD_FAST = (READ_LAT == 1);

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;

  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              ub_q, lb_q;

  logic              start;
  logic              conflict_start;
  logic              rd_load;
  logic              wr_commit;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ub, rd_lb;
  logic [15:0]       rd_word;
  logic [15:0]       rd_masked;
  logic              rd_io;
  logic              wr_io;

  logic [15:0]       mem [0:(1<<ADDR_W)-1];

  assign state_dbg = state;
  assign Ready     = (state == RD_VALID) || (state == WR_DONE);

  // State and wait counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic plus the one-cycle control strobes for the datapath.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    start          = 1'b0;
    conflict_start = 1'b0;
    rd_load        = 1'b0;
    wr_commit      = 1'b0;
    case (state)
      IDLE: begin
        if (!Mem_CE && (!Mem_OE || !Mem_WE)) begin
          start = 1'b1;
          if (!Mem_WE) begin
            // Write wins over a simultaneous read strobe.
            conflict_start = !Mem_OE;
            state_n        = WR_WAIT;
            cnt_n          = 3'd1;
          end else if (RD_FAST) begin
            // Single-cycle latency: load straight from the live address.
            rd_load = 1'b1;
            state_n = RD_VALID;
            cnt_n   = 3'd0;
          end else begin
            state_n = RD_WAIT;
            cnt_n   = 3'd1;
          end
        end
      end
      RD_WAIT: begin
        if (Mem_CE || Mem_OE) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else if (cnt == RD_LAST) begin
          rd_load = 1'b1;
          state_n = RD_VALID;
          cnt_n   = 3'd0;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      RD_VALID: begin
        if (Mem_CE || Mem_OE) state_n = IDLE;
      end
      WR_WAIT: begin
        if (Mem_CE || Mem_WE) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else if (cnt == WR_LAST) begin
          wr_commit = 1'b1;
          state_n   = WR_DONE;
          cnt_n     = 3'd0;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      WR_DONE: begin
        if (Mem_CE || Mem_WE) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  // Capture address, write data and lane enables at access start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
    end else if (start) begin
      addr_q  <= ADDR;
      wdata_q <= Data_from_CPU;
      ub_q    <= Mem_UB;
      lb_q    <= Mem_LB;
    end
  end

`ifdef LC3_MMIO_EN
  localparam logic [ADDR_W-1:0] IO_ADDR = '1;
  assign wr_io = (addr_q == IO_ADDR);
  assign rd_io = (rd_addr == IO_ADDR);
`else
  logic [15:0] unused_switches;
  assign unused_switches = Switches;
  assign wr_io = 1'b0;
  assign rd_io = 1'b0;
`endif

  // Read source select: live inputs on the start cycle, latched values later.
  always_comb begin
    rd_addr = addr_q;
    rd_ub   = ub_q;
    rd_lb   = lb_q;
    if (state == IDLE) begin
      rd_addr = ADDR;
      rd_ub   = Mem_UB;
      rd_lb   = Mem_LB;
    end
`ifdef LC3_MMIO_EN
    rd_word = rd_io ? Switches : mem[rd_addr];
`else
    rd_word = mem[rd_addr];
`endif
    rd_masked = {rd_ub ? 8'h00 : rd_word[15:8], rd_lb ? 8'h00 : rd_word[7:0]};
  end

  // Registered read data; only a completed read changes it.
  always_ff @(posedge Clk) begin
    if (Reset) Data_to_CPU <= 16'h0000;
    else if (rd_load) Data_to_CPU <= rd_masked;
  end

  // Conflict pulses in the cycle after a start with both strobes low.
  always_ff @(posedge Clk) begin
    if (Reset) Conflict <= 1'b0;
    else Conflict <= conflict_start;
  end

  // Array write at commit; each enabled lane is updated independently.
  always_ff @(posedge Clk) begin
    if (wr_commit && !Reset && !wr_io) begin
      if (!ub_q) mem[addr_q][15:8] <= wdata_q[15:8];
      if (!lb_q) mem[addr_q][7:0]  <= wdata_q[7:0];
    end
  end

`ifdef LC3_MMIO_EN
  // I/O output register, written with the same lane rules as memory.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Hex_out <= 16'h0000;
    end else if (wr_commit && wr_io) begin
      if (!ub_q) Hex_out[15:8] <= wdata_q[15:8];
      if (!lb_q) Hex_out[7:0]  <= wdata_q[7:0];
    end
  end
`else
  assign Hex_out = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3_sram_responder.sv
// tb_lc3_sram_responder: two responder instances (latencies 1/1 and 3/2)
// driven one transaction at a time and compared cycle by cycle against a
// transaction-level model of memory contents, Ready window and read data.
module tb_lc3_sram_responder;

  logic        clk;
  logic        rst;
  logic        ce [2];
  logic        oe [2];
  logic        we [2];
  logic        ub [2];
  logic        lb [2];
  logic [9:0]  addr [2];
  logic [15:0] din [2];
  logic [15:0] dout [2];
  logic        ready [2];
  logic        conflict [2];
  logic [15:0] hex [2];
  logic [2:0]  st_dbg [2];
  logic [15:0] sw;

  int rl [2] = '{1, 3};
  int wl [2] = '{1, 2};

  // Reference model state.
  logic [15:0] mm [2][1024];
  logic [15:0] exp_data [2];
  logic [15:0] exp_hex [2];

  int n_checks = 0;
  int n_fail   = 0;

  lc3_sram_responder #(.ADDR_W(10), .READ_LAT(1), .WRITE_LAT(1)) u_fast (
    .Clk(clk), .Reset(rst), .Mem_CE(ce[0]), .Mem_OE(oe[0]), .Mem_WE(we[0]),
    .Mem_UB(ub[0]), .Mem_LB(lb[0]), .ADDR(addr[0]), .Data_from_CPU(din[0]),
    .Data_to_CPU(dout[0]), .Ready(ready[0]), .Conflict(conflict[0]),
    .Switches(sw), .Hex_out(hex[0]), .state_dbg(st_dbg[0])
  );

  lc3_sram_responder #(.ADDR_W(10), .READ_LAT(3), .WRITE_LAT(2)) u_slow (
    .Clk(clk), .Reset(rst), .Mem_CE(ce[1]), .Mem_OE(oe[1]), .Mem_WE(we[1]),
    .Mem_UB(ub[1]), .Mem_LB(lb[1]), .ADDR(addr[1]), .Data_from_CPU(din[1]),
    .Data_to_CPU(dout[1]), .Ready(ready[1]), .Conflict(conflict[1]),
    .Switches(sw), .Hex_out(hex[1]), .state_dbg(st_dbg[1])
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_mask(input logic [15:0] v, input logic u, input logic l);
    return {u ? 8'h00 : v[15:8], l ? 8'h00 : v[7:0]};
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [15:0] d,
                                             input logic u, input logic l);
    return {u ? old[15:8] : d[15:8], l ? old[7:0] : d[7:0]};
  endfunction

  function automatic bit is_io(input logic [9:0] a);
`ifdef LC3_MMIO_EN
    return a == 10'h3FF;
`else
    return (a == 10'h3FF) && 1'b0;
`endif
  endfunction

  task automatic drive(input int u, input logic c, input logic o, input logic w,
                       input logic bu, input logic bl, input logic [9:0] a, input logic [15:0] d);
    ce[u] = c; oe[u] = o; we[u] = w; ub[u] = bu; lb[u] = bl; addr[u] = a; din[u] = d;
  endtask

  task automatic idle_all();
    for (int u = 0; u < 2; u++) drive(u, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'h000, 16'h0000);
  endtask

  // One transaction: strobes low for cycles 0..hold-1, released in cycle hold
  // (rel=0: strobes up, CE low; rel=1: CE up), everything idle in hold+1.
  // kind: 0 read, 1 write, 2 write with OE also low.
  task automatic run_op(input int u, input int kind, input logic [9:0] a, input logic [15:0] d,
                        input logic bu, input logic bl, input int hold, input int rel);
    bit          done;
    int          first;
    logic [15:0] new_rd;
    logic [15:0] new_hex;
    logic        o_act, w_act;
    o_act = (kind != 1) ? 1'b0 : 1'b1;
    w_act = (kind != 0) ? 1'b0 : 1'b1;
    if (kind == 0) begin
      done  = hold >= rl[u];
      first = rl[u];
    end else begin
      done  = hold >= wl[u] + 1;
      first = wl[u] + 1;
    end
    new_rd  = lane_mask(is_io(a) ? sw : mm[u][a], bu, bl);
    new_hex = (kind != 0 && is_io(a)) ? lane_merge(exp_hex[u], d, bu, bl) : exp_hex[u];
    for (int c = 0; c <= hold + 1; c++) begin
      if (c == 0)
        drive(u, 1'b0, o_act, w_act, bu, bl, a, d);
      else if (c < hold)
        drive(u, 1'b0, o_act, w_act, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              10'($urandom), 16'($urandom));
      else if (c == hold && rel == 1)
        drive(u, 1'b1, o_act, w_act, 1'b1, 1'b1, 10'($urandom), 16'($urandom));
      else
        drive(u, (c == hold) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'($urandom), 16'($urandom));
      @(negedge clk);
      check_eq($sformatf("ready u%0d k%0d c%0d", u, kind, c), 32'(ready[u]),
               32'(done && c >= first && c <= hold));
      check_eq($sformatf("conflict u%0d c%0d", u, c), 32'(conflict[u]), 32'(kind == 2 && c == 1));
      check_eq($sformatf("data u%0d k%0d c%0d", u, kind, c), 32'(dout[u]),
               32'((kind == 0 && done && c >= first) ? new_rd : exp_data[u]));
      check_eq($sformatf("hex u%0d c%0d", u, c), 32'(hex[u]),
               32'((kind != 0 && done && c >= first) ? new_hex : exp_hex[u]));
      @(posedge clk);
      #1;
    end
    if (done) begin
      if (kind == 0) exp_data[u] = new_rd;
      else if (is_io(a)) exp_hex[u] = new_hex;
      else mm[u][a] = lane_merge(mm[u][a], d, bu, bl);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int u = 0; u < 2; u++) begin
      check_eq($sformatf("%s ready u%0d", tag, u), 32'(ready[u]), 32'd0);
      check_eq($sformatf("%s conflict u%0d", tag, u), 32'(conflict[u]), 32'd0);
      check_eq($sformatf("%s data u%0d", tag, u), 32'(dout[u]), 32'h0000);
      check_eq($sformatf("%s hex u%0d", tag, u), 32'(hex[u]), 32'h0000);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      exp_data[u] = 16'h0000;
      exp_hex[u]  = 16'h0000;
      for (int i = 0; i < 1024; i++) mm[u][i] = 16'h0000;
    end
    sw  = 16'h0000;
    rst = 1'b1;
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Initialise the working region of both arrays.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++)
        run_op(u, 1, 10'(i), 16'($urandom), 1'b0, 1'b0, wl[u] + 1, 0);

    // Basic write then read.
    run_op(0, 1, 10'h005, 16'hBEEF, 1'b0, 1'b0, 2, 0);
    run_op(0, 0, 10'h005, 16'h0000, 1'b0, 1'b0, 2, 0);
    // Lane-masked write and read.
    run_op(0, 1, 10'h005, 16'h1234, 1'b1, 1'b0, 2, 0);
    run_op(0, 0, 10'h005, 16'h0000, 1'b0, 1'b1, 2, 0);
    run_op(0, 0, 10'h005, 16'h0000, 1'b0, 1'b0, 2, 1);
    // Aborted write leaves memory untouched.
    run_op(0, 1, 10'h006, 16'h0000, 1'b0, 1'b0, 2, 0);
    run_op(0, 1, 10'h006, 16'hFFFF, 1'b0, 1'b0, 1, 0);
    run_op(0, 0, 10'h006, 16'h0000, 1'b0, 1'b0, 2, 0);
    // Both strobes low: write wins, Conflict pulses.
    run_op(0, 2, 10'h007, 16'h00FF, 1'b0, 1'b0, 2, 0);
    run_op(0, 0, 10'h007, 16'h0000, 1'b0, 1'b0, 2, 0);
    // No-lane write still completes.
    run_op(0, 1, 10'h007, 16'hAAAA, 1'b1, 1'b1, 2, 0);
    run_op(0, 0, 10'h007, 16'h0000, 1'b0, 1'b0, 2, 0);
    // Slow instance: three-cycle read latency and its abort boundary.
    run_op(1, 1, 10'h005, 16'hBEEF, 1'b0, 1'b0, 3, 0);
    run_op(1, 0, 10'h005, 16'h0000, 1'b0, 1'b0, 4, 0);
    run_op(1, 0, 10'h003, 16'h0000, 1'b0, 1'b0, 2, 1);
    run_op(1, 1, 10'h003, 16'h5555, 1'b0, 1'b0, 2, 1);
    run_op(1, 0, 10'h003, 16'h0000, 1'b0, 1'b0, 3, 0);

    // Reset during the commit cycle of a write aborts it.
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h009, 16'hDEAD);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_all();
    @(negedge clk);
    check_reset_vals("midreset");
    for (int u = 0; u < 2; u++) begin
      exp_data[u] = 16'h0000;
      exp_hex[u]  = 16'h0000;
    end
    @(posedge clk);
    #1;
    run_op(0, 0, 10'h009, 16'h0000, 1'b0, 1'b0, 2, 0);

    // Top address: I/O location or plain memory depending on the build.
    sw = 16'hA5A5;
    run_op(0, 0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 2, 0);
    run_op(0, 1, 10'h3FF, 16'h0042, 1'b0, 1'b0, 2, 0);
    run_op(0, 1, 10'h3FF, 16'h9900, 1'b0, 1'b1, 2, 0);
    sw = 16'h3C3C;
    run_op(0, 0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 2, 0);

    // Randomized transactions over the initialised region.
    for (int n = 0; n < 150; n++) begin
      int u;
      u  = $urandom_range(0, 1);
      sw = 16'($urandom);
      run_op(u, $urandom_range(0, 2), 10'($urandom_range(0, 15)), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(1, 5), $urandom_range(0, 1));
    end

    // Read back the whole region with both lanes enabled.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++)
        run_op(u, 0, 10'(i), 16'h0000, 1'b0, 1'b0, rl[u] + 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
